// File: rtl/compk_accum_ctrl_if.sv
// ---------------------------------------------------------------------------
// compk_accum_ctrl_if
// Job/result bundle between a host and the compk_accum_ctrl sequencer.
//
// Signals
//   start      host -> ctrl  job request (only honoured while the ctrl is idle)
//   k          host -> ctrl  threshold, latched when a job is accepted
//   step       host -> ctrl  increment, latched when a job is accepted
//   busy       ctrl -> host  high in every state except IDLE
//   done       ctrl -> host  one-cycle pulse when a job completes
//   sum_out    ctrl -> host  working sum
//   iter_count ctrl -> host  number of additions performed
//   hit        ctrl -> host  job ended because k < sum
//   overflow   ctrl -> host  job ended on adder carry-out
//   timeout    ctrl -> host  job ended on the iteration limit
//
// Modports: master (host side), slave (controller side).
// ---------------------------------------------------------------------------
interface compk_accum_ctrl_if #(
  parameter int DATA_W = 6
) ();

  logic              start;
  logic [DATA_W-1:0] k;
  logic [DATA_W-1:0] step;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] sum_out;
  logic [DATA_W-1:0] iter_count;
  logic              hit;
  logic              overflow;
  logic              timeout;

  modport master (
    output start, k, step,
    input  busy, done, sum_out, iter_count, hit, overflow, timeout
  );

  modport slave (
    input  start, k, step,
    output busy, done, sum_out, iter_count, hit, overflow, timeout
  );

endinterface

// File: rtl/compk_accum_ctrl.sv
// ---------------------------------------------------------------------------
// compk_accum_ctrl
// Sequencing controller for the "k < accumulated sum" comparator datapath.
// A job latches k and step, then alternates ACCUM (sum += step) and CHECK
// (compare the registered sum against k) until the sum exceeds k, the adder
// carries out, or the iteration limit is reached. All arithmetic is unsigned.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (aborts a running job, no done pulse)
//   bus   compk_accum_ctrl_if.slave: start/k/step in, busy/done/results out
//
// Parameters
//   DATA_W    width of k, step, sum and iteration count
//   MAX_ITER  iteration limit, legal range 1 .. 2**DATA_W-1
//
// Build option
//   COMPK_ACCUM_SAT_EN  when defined the adder saturates at 2**DATA_W-1
//                       instead of wrapping; the carry flag is forced to 0,
//                       so the overflow result can never be reported.
// ---------------------------------------------------------------------------
module compk_accum_ctrl #(
  parameter int DATA_W   = 6,
  parameter int MAX_ITER = 63
) (
  input  logic                clk,
  input  logic                rst,
  compk_accum_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ACCUM = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0] MAX_ITER_W = DATA_W'(MAX_ITER);

  state_t            r_state;
  state_t            w_next_state;

  logic [DATA_W-1:0] r_k;
  logic [DATA_W-1:0] r_step;
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_iter;
  logic              r_carry;
  logic              r_hit;
  logic              r_ovf;
  logic              r_timeout;

  logic [DATA_W:0]   w_add;
  logic [DATA_W-1:0] w_sum_next;
  logic              w_carry;
  logic              w_hit_cond;
  logic              w_timeout_cond;

  // Adder is one bit wider than the datapath so the carry-out is visible.
  assign w_add = {1'b0, r_sum} + {1'b0, r_step};

`ifdef COMPK_ACCUM_SAT_EN
  assign w_sum_next = w_add[DATA_W] ? {DATA_W{1'b1}} : w_add[DATA_W-1:0];
  assign w_carry    = 1'b0;
`else
  assign w_sum_next = w_add[DATA_W-1:0];
  assign w_carry    = w_add[DATA_W];
`endif

  // CHECK works on the registered sum/count, never on the adder output.
  assign w_hit_cond     = (r_k < r_sum);
  assign w_timeout_cond = (r_iter == MAX_ITER_W);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment first guarantees a value on every path, so
  // no latch is inferred even if a branch below forgets to assign.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (bus.start) w_next_state = LOAD;
      LOAD:  w_next_state = ACCUM;
      ACCUM: w_next_state = CHECK;
      CHECK: begin
        if (w_hit_cond || r_carry || w_timeout_cond) w_next_state = DONE;
        else                                         w_next_state = ACCUM;
      end
      DONE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k       <= '0;
      r_step    <= '0;
      r_sum     <= '0;
      r_iter    <= '0;
      r_carry   <= 1'b0;
      r_hit     <= 1'b0;
      r_ovf     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_k       <= bus.k;
          r_step    <= bus.step;
          r_sum     <= '0;
          r_iter    <= '0;
          r_carry   <= 1'b0;
          r_hit     <= 1'b0;
          r_ovf     <= 1'b0;
          r_timeout <= 1'b0;
        end
        ACCUM: begin
          r_sum   <= w_sum_next;
          r_iter  <= r_iter + DATA_W'(1);
          r_carry <= w_carry;
        end
        CHECK: begin
          // Priority: hit beats overflow beats timeout, so exactly one flag
          // is raised when the job terminates.
          if (w_hit_cond)          r_hit     <= 1'b1;
          else if (r_carry)        r_ovf     <= 1'b1;
          else if (w_timeout_cond) r_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);
  assign bus.sum_out    = r_sum;
  assign bus.iter_count = r_iter;
  assign bus.hit        = r_hit;
  assign bus.overflow   = r_ovf;
  assign bus.timeout    = r_timeout;

endmodule
